resp_capture_sink: RTL

Downstream consumer of the exhaustive-pattern DUT harness. Each cycle it takes the applied stimulus vector and the DUT's single-bit response, and buffers the {pattern, response} pair in a small FIFO. That FIFO drains to the logging side over a valid/ready handshake. In parallel the block compacts every sample into a MISR signature for golden-vs-suspect comparison in trojan detection runs.

---
 rtl/resp_capture_sink.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/resp_capture_sink.sv
// resp_capture_sink: captures {pattern, response} samples from the DUT harness,
// buffers them in a first-word-fall-through FIFO toward the logger, and compacts
// every sample into a MISR signature.
// Optional golden-response checking is enabled with `define RESP_CAPTURE_GOLDEN_EN.
module resp_capture_sink #(
    parameter int unsigned N_WIDTH      = 4,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned NUM_PATTERNS = 16,
    parameter int unsigned MISR_WIDTH   = 16,
    parameter logic [MISR_WIDTH-1:0] POLY = 16'h1021,
    parameter logic [MISR_WIDTH-1:0] SEED = 16'h0000
) (
    input  logic                                  CK,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic                                  in_valid,
    input  logic [N_WIDTH-1:0]                    in_pattern,
    input  logic                                  in_resp,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [N_WIDTH-1:0]                    out_pattern,
    output logic                                  out_resp,
    output logic [$clog2(NUM_PATTERNS+1)-1:0]     count,
    output logic [MISR_WIDTH-1:0]                 signature,
    output logic                                  overflow,
`ifdef RESP_CAPTURE_GOLDEN_EN
    input  logic                                  exp_resp,
    output logic [$clog2(NUM_PATTERNS+1)-1:0]     mismatch_cnt,
    output logic [N_WIDTH-1:0]                    first_mismatch,
`endif
    output logic                                  done
);

    localparam int unsigned CNT_W = $clog2(NUM_PATTERNS + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    localparam int unsigned ENT_W = N_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, DONE} state_t;

    state_t               state, state_next;
    logic [ENT_W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0]     rd_ptr, rd_next, wr_ptr, wr_next, rd_inc;
    logic [OCC_W-1:0]     occ, occ_next;
    logic                 valid_next;
    logic [N_WIDTH-1:0]   pat_next;
    logic                 resp_next;
    logic [CNT_W-1:0]     cnt_next;
    logic [MISR_WIDTH-1:0] sig_next;
    logic                 ovf_next;
    logic                 done_next;
    logic                 push, pop, sample, start_run, full;
`ifdef RESP_CAPTURE_GOLDEN_EN
    logic [CNT_W-1:0]     mm_next;
    logic [N_WIDTH-1:0]   first_next;
`endif

    assign rd_inc = rd_ptr + PTR_W'(1);

    // Next-state, FIFO bookkeeping, counters and MISR update
    always_comb begin
        state_next = state;
        rd_next    = rd_ptr;
        wr_next    = wr_ptr;
        occ_next   = occ;
        pat_next   = out_pattern;
        resp_next  = out_resp;
        cnt_next   = count;
        sig_next   = signature;
        ovf_next   = overflow;
        push       = 1'b0;
        pop        = 1'b0;
`ifdef RESP_CAPTURE_GOLDEN_EN
        mm_next    = mismatch_cnt;
        first_next = first_mismatch;
`endif
        full       = (occ == OCC_W'(DEPTH));
        sample     = (state == CAPTURE) && in_valid;
        start_run  = start && ((state == IDLE) || (state == DONE));

        if (start_run) begin
            state_next = CAPTURE;
            rd_next    = '0;
            wr_next    = '0;
            occ_next   = '0;
            cnt_next   = '0;
            sig_next   = SEED;
            ovf_next   = 1'b0;
`ifdef RESP_CAPTURE_GOLDEN_EN
            mm_next    = '0;
            first_next = '0;
`endif
        end else begin
            pop  = out_valid && out_ready;
            push = sample && (!full || pop);

            if (sample) begin
                cnt_next = count + CNT_W'(1);
                sig_next = {signature[MISR_WIDTH-2:0], 1'b0}
                         ^ (signature[MISR_WIDTH-1] ? POLY : '0)
                         ^ MISR_WIDTH'({in_pattern, in_resp});
                if (!push) begin
                    ovf_next = 1'b1;
                end
                if (count == CNT_W'(NUM_PATTERNS - 1)) begin
                    state_next = DRAIN;
                end
`ifdef RESP_CAPTURE_GOLDEN_EN
                if (in_resp != exp_resp) begin
                    mm_next = mismatch_cnt + CNT_W'(1);
                    if (mismatch_cnt == '0) begin
                        first_next = in_pattern;
                    end
                end
`endif
            end

            if (pop) begin
                rd_next = rd_inc;
            end
            if (push) begin
                wr_next = wr_ptr + PTR_W'(1);
            end

            unique case ({push, pop})
                2'b10:   occ_next = occ + OCC_W'(1);
                2'b01:   occ_next = occ - OCC_W'(1);
                default: occ_next = occ;
            endcase

            // Head register: bypass the pushed entry when it becomes the head
            if (push && ((occ == '0) || (pop && (occ == OCC_W'(1))))) begin
                pat_next  = in_pattern;
                resp_next = in_resp;
            end else if (pop && (occ > OCC_W'(1))) begin
                {pat_next, resp_next} = mem[rd_inc];
            end

            if ((state == DRAIN) && (occ == '0)) begin
                state_next = DONE;
            end
        end

        valid_next = (occ_next != '0);
        done_next  = (state_next == DONE);
    end

    // FIFO storage write port
    always_ff @(posedge CK) begin
        if (push) begin
            mem[wr_ptr] <= {in_pattern, in_resp};
        end
    end

    // State and registered outputs
    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            occ         <= '0;
            out_valid   <= 1'b0;
            out_pattern <= '0;
            out_resp    <= 1'b0;
            count       <= '0;
            signature   <= SEED;
            overflow    <= 1'b0;
            done        <= 1'b0;
`ifdef RESP_CAPTURE_GOLDEN_EN
            mismatch_cnt   <= '0;
            first_mismatch <= '0;
`endif
        end else begin
            state       <= state_next;
            rd_ptr      <= rd_next;
            wr_ptr      <= wr_next;
            occ         <= occ_next;
            out_valid   <= valid_next;
            out_pattern <= pat_next;
            out_resp    <= resp_next;
            count       <= cnt_next;
            signature   <= sig_next;
            overflow    <= ovf_next;
            done        <= done_next;
`ifdef RESP_CAPTURE_GOLDEN_EN
            mismatch_cnt   <= mm_next;
            first_mismatch <= first_next;
`endif
        end
    end

endmodule
